// File: rtl/tetris_step_ctrl.sv
// Game-step controller for a 7x12 single-cell Tetris board: spawn, gravity, moves, landing, row clear.
// Optional hard drop is compiled in when TETRIS_HARD_DROP_EN is defined; otherwise `drop` is ignored.
module tetris_step_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        tick,
    input  logic        move_left,
    input  logic        move_right,
    input  logic        drop,
    input  logic [2:0]  colour_in,
    output logic [6:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour_draw,
    output logic [35:0] c1,
    output logic [35:0] c2,
    output logic [35:0] c3,
    output logic [35:0] c4,
    output logic [35:0] c5,
    output logic [35:0] c6,
    output logic [35:0] c7,
    output logic        landed,
    output logic        busy,
    output logic [7:0]  lines_cleared,
    output logic        game_over
);

    typedef enum logic [2:0] {
        IDLE, SPAWN, FALL, LAND, CLEAR_SCAN, CLEAR_SHIFT, OVER
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  k_q, k_d;
    logic [3:0]  r_q, r_d;
    logic [3:0]  s_q, s_d;
    logic [2:0]  colour_q, colour_d;
    logic [35:0] col_q [7];
    logic [35:0] col_d [7];
    logic [6:0]  x_q, x_d, y_q, y_d;
    logic        landed_q, landed_d;
    logic        busy_q, busy_d;
    logic [7:0]  lines_q, lines_d;
    logic        game_over_q, game_over_d;
    logic        drop_mode_q, drop_mode_d;

    logic        gravity;
    logic        blocked_below;
    logic        left_free;
    logic        right_free;
    logic        row_full;
    logic [5:0]  land_lsb;
    logic [35:0] shift_col [7];

    // Row 0 sits in the top bits of each column word.
    function automatic logic [2:0] cell_at(input logic [35:0] col, input logic [3:0] row);
        logic [5:0] lsb;
        lsb = 6'd33 - 6'd3 * {2'b00, row};
        return col[lsb +: 3];
    endfunction

    always_comb begin
        blocked_below = (r_q == 4'd11) || (cell_at(col_q[k_q], r_q + 4'd1) != 3'b000);
        left_free     = (k_q != 3'd0) && (cell_at(col_q[k_q - 3'd1], r_q) == 3'b000);
        right_free    = (k_q != 3'd6) && (cell_at(col_q[k_q + 3'd1], r_q) == 3'b000);
        land_lsb      = 6'd33 - 6'd3 * {2'b00, r_q};

        row_full = 1'b1;
        for (int j = 0; j < 7; j++) begin
            if (cell_at(col_q[j], s_q) == 3'b000) row_full = 1'b0;
        end

        // Rows above the cleared row s slide down by one; row 0 refills empty.
        for (int j = 0; j < 7; j++) begin
            shift_col[j]        = col_q[j];
            shift_col[j][35:33] = 3'b000;
            for (int i = 1; i < 12; i++) begin
                if (4'(i) <= s_q) shift_col[j][33 - 3*i +: 3] = col_q[j][36 - 3*i +: 3];
            end
        end
    end

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        k_d         = k_q;
        r_d         = r_q;
        s_d         = s_q;
        colour_d    = colour_q;
        col_d       = col_q;
        lines_d     = lines_q;
        game_over_d = game_over_q;
        drop_mode_d = drop_mode_q;
        landed_d    = 1'b0;
        gravity     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) state_d = SPAWN;
            end
            SPAWN: begin
                k_d      = 3'd3;
                r_d      = 4'd0;
                colour_d = (colour_in == 3'b000) ? 3'b111 : colour_in;
                if (cell_at(col_q[3], 4'd0) != 3'b000) begin
                    state_d     = OVER;
                    game_over_d = 1'b1;
                end else begin
                    state_d = FALL;
                end
            end
            FALL: begin
`ifdef TETRIS_HARD_DROP_EN
                if (drop) drop_mode_d = 1'b1;
                gravity = drop | drop_mode_q | tick;
`else
                gravity = tick;
`endif
                if (gravity) begin
                    if (blocked_below) state_d = LAND;
                    else               r_d     = r_q + 4'd1;
                end else if (move_left) begin
                    if (left_free) k_d = k_q - 3'd1;
                end else if (move_right) begin
                    if (right_free) k_d = k_q + 3'd1;
                end
            end
            LAND: begin
                col_d[k_q][land_lsb +: 3] = colour_q;
                landed_d    = 1'b1;
                drop_mode_d = 1'b0;
                s_d         = 4'd11;
                state_d     = CLEAR_SCAN;
            end
            CLEAR_SCAN: begin
                if (row_full)            state_d = CLEAR_SHIFT;
                else if (s_q == 4'd0)    state_d = SPAWN;
                else                     s_d     = s_q - 4'd1;
            end
            CLEAR_SHIFT: begin
                col_d   = shift_col;
                lines_d = (lines_q == 8'hFF) ? lines_q : lines_q + 8'd1;
                state_d = CLEAR_SCAN;
            end
            OVER: begin
                if (start) begin
                    for (int j = 0; j < 7; j++) col_d[j] = '0;
                    lines_d     = 8'd0;
                    game_over_d = 1'b0;
                    state_d     = SPAWN;
                end
            end
            default: state_d = IDLE;
        endcase

        x_d    = 7'd10 * {4'b0000, k_d};
        y_d    = 7'd10 * {3'b000, r_d};
        busy_d = (state_d == SPAWN) || (state_d == LAND) ||
                 (state_d == CLEAR_SCAN) || (state_d == CLEAR_SHIFT);
    end

`ifndef TETRIS_HARD_DROP_EN
    logic unused_drop;
    assign unused_drop = drop;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= 3'd0;
            r_q         <= 4'd0;
            s_q         <= 4'd0;
            colour_q    <= 3'd0;
            x_q         <= 7'd0;
            y_q         <= 7'd0;
            landed_q    <= 1'b0;
            busy_q      <= 1'b0;
            lines_q     <= 8'd0;
            game_over_q <= 1'b0;
            drop_mode_q <= 1'b0;
            // NOTE: the board is plain flops, not RAM, so every cell is cleared by reset.
            for (int j = 0; j < 7; j++) col_q[j] <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so all flops update together on the edge.
            state_q     <= state_d;
            k_q         <= k_d;
            r_q         <= r_d;
            s_q         <= s_d;
            colour_q    <= colour_d;
            x_q         <= x_d;
            y_q         <= y_d;
            landed_q    <= landed_d;
            busy_q      <= busy_d;
            lines_q     <= lines_d;
            game_over_q <= game_over_d;
            drop_mode_q <= drop_mode_d;
            col_q       <= col_d;
        end
    end

    assign x             = x_q;
    assign y             = y_q;
    assign colour_draw   = colour_q;
    assign landed        = landed_q;
    assign busy          = busy_q;
    assign lines_cleared = lines_q;
    assign game_over     = game_over_q;
    assign c1 = col_q[0];
    assign c2 = col_q[1];
    assign c3 = col_q[2];
    assign c4 = col_q[3];
    assign c5 = col_q[4];
    assign c6 = col_q[5];
    assign c7 = col_q[6];

endmodule
